// File: rtl/countdown_timer.sv
// MM:SS.cc countdown timer with set buttons, pause/resume and a timed alarm phase.
// Time is held as six BCD digits; a prescaler derives the 10 ms tick from CLK.
module countdown_timer #(
   parameter int TICK_DIV  = 500000,
   parameter int ALARM_LEN = 300
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       SECUP,
   input  logic       MINUP,
   input  logic       CLR,
   output logic [3:0] MIN10,
   output logic [3:0] MIN1,
   output logic [3:0] SEC10,
   output logic [3:0] SEC1,
   output logic [3:0] CSEC10,
   output logic [3:0] CSEC1,
   output logic       RUNNING,
   output logic       ALARM,
   output logic       TICK
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = (ALARM_LEN > 1) ? $clog2(ALARM_LEN + 1) : 1;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALRM} state_t;

   state_t             state, state_n;
   logic [5:0][3:0]    dig, dig_n, dec;   // [5]=MIN10 .. [0]=CSEC1
   logic [PW-1:0]      presc, presc_n;
   logic [AW-1:0]      acnt, acnt_n;
   logic               active, borrow;
   logic [3:0]         lim;

   function automatic logic [7:0] inc60(input logic [3:0] tens, input logic [3:0] units);
      if (units == 4'd9) inc60 = {(tens == 4'd5) ? 4'd0 : tens + 4'd1, 4'd0};
      else               inc60 = {tens, units + 4'd1};
   endfunction

   assign active = (state == RUN) || (state == ALRM);
   assign TICK   = active && (presc == PW'(TICK_DIV - 1));

   // Borrow ripples up from CSEC1; tens digits of seconds/minutes wrap to 5.
   always_comb begin
      dec    = dig;
      borrow = 1'b1;
      lim    = 4'd9;
      for (int i = 0; i < 6; i++) begin
         lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
         if (borrow) begin
            if (dig[i] == 4'd0) dec[i] = lim;
            else begin
               dec[i] = dig[i] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   // User pulses outrank a coincident tick: CLR/START suppress that tick's update.
   always_comb begin
      state_n = state;
      dig_n   = dig;
      acnt_n  = acnt;
      presc_n = active ? (TICK ? '0 : presc + 1'b1) : '0;
      if (CLR) begin
         state_n = IDLE;
         dig_n   = '0;
         acnt_n  = '0;
         presc_n = '0;
      end else if (START) begin
         presc_n = '0;
         case (state)
            IDLE, PAUSE: if (|dig) state_n = RUN;
            RUN:         state_n = PAUSE;
            default: begin
               state_n = IDLE;
               acnt_n  = '0;
            end
         endcase
      end else if (state == IDLE || state == PAUSE) begin
         if (MINUP)      dig_n[5:4] = inc60(dig[5], dig[4]);
         else if (SECUP) dig_n[3:2] = inc60(dig[3], dig[2]);
      end else if (TICK) begin
         if (state == RUN) begin
            dig_n = dec;
            if (dig == 24'h000001) begin
               state_n = ALRM;
               acnt_n  = '0;
            end
         end else if (acnt == AW'(ALARM_LEN - 1)) begin
            state_n = IDLE;
            acnt_n  = '0;
         end else begin
            acnt_n = acnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         dig     <= '0;
         presc   <= '0;
         acnt    <= '0;
         RUNNING <= 1'b0;
         ALARM   <= 1'b0;
      end else begin
         state   <= state_n;
         dig     <= dig_n;
         presc   <= presc_n;
         acnt    <= acnt_n;
         RUNNING <= (state_n == RUN);
         ALARM   <= (state_n == ALRM);
      end
   end

   assign MIN10  = dig[5];
   assign MIN1   = dig[4];
   assign SEC10  = dig[3];
   assign SEC1   = dig[2];
   assign CSEC10 = dig[1];
   assign CSEC1  = dig[0];
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a centisecond-integer reference model checked every
// cycle, pinned by hand-computed expectations for the key scenarios.
module tb_countdown_timer;
   localparam int TD = 4;
   localparam int AL = 3;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       start = 1'b0, secup = 1'b0, minup = 1'b0, clr = 1'b0;
   logic [3:0] min10, min1, sec10, sec1, csec10, csec1;
   logic       running, alarm, tick;

   int errors = 0, checks = 0;
   bit cmp_en = 1'b0;

   // Reference state: remaining time in centiseconds, mode 0=idle 1=run 2=pause 3=alarm,
   // cycles into the current tick interval, ticks spent alarming.
   int t = 0, mode = 0, pc = 0, ac = 0;

   countdown_timer #(.TICK_DIV(TD), .ALARM_LEN(AL)) dut (
      .CLK(clk), .RST(rst_n), .START(start), .SECUP(secup), .MINUP(minup), .CLR(clr),
      .MIN10(min10), .MIN1(min1), .SEC10(sec10), .SEC1(sec1), .CSEC10(csec10), .CSEC1(csec1),
      .RUNNING(running), .ALARM(alarm), .TICK(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] bcd_of(input int cs);
      int m, s, c;
      m = cs / 6000; s = (cs / 100) % 60; c = cs % 100;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   function automatic logic [23:0] disp();
      return {min10, min1, sec10, sec1, csec10, csec1};
   endfunction

   initial begin : model
      bit act, tk;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            t = 0; mode = 0; pc = 0; ac = 0;
         end else begin
            act = (mode == 1 || mode == 3);
            tk  = act && (pc == TD - 1);
            if (clr) begin
               t = 0; mode = 0; pc = 0; ac = 0;
            end else if (start) begin
               pc = 0;
               if ((mode == 0 || mode == 2) && t != 0) mode = 1;
               else if (mode == 1) mode = 2;
               else if (mode == 3) begin mode = 0; ac = 0; end
            end else if (mode == 0 || mode == 2) begin
               if (minup)      t = (((t / 6000) + 1) % 60) * 6000 + t % 6000;
               else if (secup) t = (t / 6000) * 6000 + ((((t / 100) % 60) + 1) % 60) * 100 + t % 100;
            end else begin
               pc = tk ? 0 : pc + 1;
               if (tk && mode == 1) begin
                  t = t - 1;
                  if (t == 0) begin mode = 3; ac = 0; end
               end else if (tk) begin
                  ac = ac + 1;
                  if (ac == AL) begin mode = 0; ac = 0; end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("digits",  disp(), bcd_of(t));
         chk("running", running, mode == 1);
         chk("alarm",   alarm,   mode == 3);
         chk("tick",    tick,    (mode == 1 || mode == 3) && pc == TD - 1);
      end
   end

   task automatic drive(input bit s, input bit su, input bit mu, input bit c);
      @(negedge clk);
      start = s; secup = su; minup = mu; clr = c;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_digits", disp(), 24'h0);
      chk("reset_flags", {running, alarm, tick}, 3'b000);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // Set and wrap
      drive(0, 0, 1, 0); drive(0, 0, 1, 0);
      for (int i = 0; i < 61; i++) drive(0, 1, 0, 0);
      idle(1);
      chk("set_wrap", disp(), 24'h020100);

      // Borrow chain and first-tick latency
      drive(0, 0, 0, 1); drive(0, 0, 1, 0); drive(1, 0, 0, 0);
      idle(1);
      chk("start_running", running, 1'b1);
      chk("no_early_tick", tick, 1'b0);
      idle(3);
      chk("first_tick", tick, 1'b1);
      idle(1);
      chk("borrow_chain", disp(), 24'h005999);

      // Expiry and alarm duration
      drive(0, 0, 0, 1); drive(0, 1, 0, 0); drive(1, 0, 0, 0);
      idle(400);
      chk("pre_expiry", {disp(), 3'(alarm)}, {24'h000001, 3'd0});
      idle(1);
      chk("expiry", {disp(), 3'(alarm)}, {24'h0, 3'd1});
      idle(11);
      chk("alarm_hold", alarm, 1'b1);
      idle(1);
      chk("alarm_end", {running, alarm}, 2'b00);

      // Pause, edit while paused, START beats SECUP
      drive(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 0);
      drive(1, 0, 0, 0);
      idle(9);
      drive(1, 0, 0, 0);
      idle(20);
      chk("paused", {disp(), 3'(running)}, {24'h000498, 3'd0});
      drive(0, 1, 0, 0);
      idle(1);
      chk("pause_secup", disp(), 24'h000598);
      drive(1, 1, 0, 0);
      idle(1);
      chk("start_over_secup", {disp(), 3'(running)}, {24'h000598, 3'd1});

      // START at zero ignored; START during alarm acknowledges
      drive(0, 0, 0, 1); drive(1, 0, 0, 0);
      idle(1);
      chk("start_at_zero", {running, alarm}, 2'b00);
      drive(0, 1, 0, 0); drive(1, 0, 0, 0);
      idle(401);
      chk("in_alarm", alarm, 1'b1);
      drive(1, 0, 0, 0);
      idle(1);
      chk("alarm_ack", {running, alarm}, 2'b00);

      // Asynchronous reset mid-run
      drive(0, 0, 1, 0); drive(1, 0, 0, 0);
      idle(10);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst", {disp(), running, tick}, {24'h0, 2'b00});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // CLR beats START while running
      drive(0, 0, 1, 0); drive(1, 0, 0, 0);
      idle(6);
      drive(1, 0, 0, 1);
      idle(1);
      chk("clr_over_start", {disp(), running}, {24'h0, 1'b0});

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++)
         drive($urandom_range(11) == 0, $urandom_range(5) == 0,
               $urandom_range(150) == 0, $urandom_range(300) == 0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
